// File: rtl/seq_comparator_if.sv
// ---------------------------------------------------------------------------
// seq_comparator_if
//   Request/response bundle between a requester (master) and the
//   sequential comparator (slave).
//
//   Handshake: the master raises start with in0/in1/mode valid; the slave
//   accepts it only on a rising edge where busy=0.  A start seen while
//   busy=1 is dropped, not queued.  The result is valid in the single cycle
//   where done=1 and stays on result until the next accepted start.
//
//   Signals
//     start   master->slave  request a comparison
//     in0     master->slave  first operand  (WIDTH bits)
//     in1     master->slave  second operand (WIDTH bits)
//     mode    master->slave  00 eq, 01 ltu, 10 lt (signed), 11 ne
//     busy    slave->master  comparison in progress
//     done    slave->master  one-cycle completion pulse
//     result  slave->master  comparison outcome
// ---------------------------------------------------------------------------
interface seq_comparator_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic             result;

    modport master (
        output start, in0, in1, mode,
        input  busy, done, result
    );

    modport slave (
        input  start, in0, in1, mode,
        output busy, done, result
    );
endinterface

// File: rtl/seq_comparator.sv
// ---------------------------------------------------------------------------
// seq_comparator
//   Compares two WIDTH-bit operands CHUNK bits per cycle, most significant
//   chunk first, stopping as soon as a differing chunk decides the outcome.
//   Modes: 00 eq, 01 ltu (unsigned in0 < in1), 10 lt (signed), 11 ne.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        seq_comparator_if slave (start/in0/in1/mode in,
//                busy/done/result out)
//     dbg_state  current FSM state (0 IDLE, 1 CMP, 2 DONE) for observation
// ---------------------------------------------------------------------------
module seq_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_comparator_if.slave     bus,
    output logic [1:0]          dbg_state
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Flipping the sign bit of both operands maps two's-complement order
    // onto unsigned order, so one unsigned chunk compare serves both modes.
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       mode_q;
    logic [IDX_W-1:0] idx_q;
    logic             result_q;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic             differ;
    logic             last;
    logic             outcome;

    // Current chunk under examination and the decision it implies.
    always_comb begin
        slice_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
        slice_b = b_q[int'(idx_q) * CHUNK +: CHUNK];
        differ  = (slice_a != slice_b);
        last    = (idx_q == '0);
        case (mode_q)
            2'b00:   outcome = ~differ;
            2'b11:   outcome = differ;
            default: outcome = differ & (slice_a < slice_b);
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = CMP;
                end
            end
            CMP: begin
                if (differ || last) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, chunk index and result register.  Operands and mode
    // are captured only on the accepting edge; later input changes and
    // starts during CMP/DONE leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            idx_q    <= '0;
            result_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.mode == 2'b10) begin
                            a_q <= bus.in0 ^ SIGN_MASK;
                            b_q <= bus.in1 ^ SIGN_MASK;
                        end else begin
                            a_q <= bus.in0;
                            b_q <= bus.in1;
                        end
                        mode_q <= bus.mode;
                        idx_q  <= IDX_TOP;
                    end
                end
                CMP: begin
                    if (differ || last) begin
                        result_q <= outcome;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_seq_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_comparator
//   Directed and random checks of seq_comparator at WIDTH=16, CHUNK=4.
//   Expected outcomes and latencies come from a plain arithmetic model of
//   the comparison rules (integer compare, highest differing bit).
// ---------------------------------------------------------------------------
module tb_seq_comparator;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    seq_comparator_if #(.WIDTH(WIDTH)) bus ();

    seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model.
    function automatic logic model_res(input logic [15:0] a, input logic [15:0] b,
                                       input logic [1:0] m);
        case (m)
            2'b00:   return (a == b);
            2'b01:   return (a < b);
            2'b10:   return ($signed(a) < $signed(b));
            default: return (a != b);
        endcase
    endfunction

    // Number of chunks examined: down to the chunk holding the highest
    // differing bit, or all of them when the operands are equal.
    function automatic int model_chunks(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        int top;
        x = a ^ b;
        if (x == 16'h0) return N;
        top = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) top = i;
        end
        return N - top / CHUNK;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one comparison starting at the current time (just after a
    // negedge, DUT in IDLE).  Inputs are scrambled right after acceptance.
    // Returns one cycle after done, at a negedge, with the DUT back in IDLE
    // so the caller can start the next operation immediately.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] m);
        logic exp_res;
        int   exp_j;
        int   cyc;
        bit   got;
        exp_res = model_res(a, b, m);
        exp_j   = model_chunks(a, b);
        bus.start = 1'b1;
        bus.in0   = a;
        bus.in1   = b;
        bus.mode  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in0   = 16'($urandom);
        bus.in1   = 16'($urandom);
        bus.mode  = 2'($urandom_range(0, 3));
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < N + 3) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) got = 1'b1;
            else check({tag, "_busy_cmp"}, {31'b0, bus.busy}, 32'd1);
        end
        check({tag, "_done_seen"}, {31'b0, got}, 32'd1);
        check({tag, "_latency"}, cyc, exp_j + 1);
        check({tag, "_result"}, {31'b0, bus.result}, {31'b0, exp_res});
        check({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd1);
        check({tag, "_state_done"}, {30'b0, dbg_state}, 32'd2);
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_idle_done"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_hold_result"}, {31'b0, bus.result}, {31'b0, exp_res});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [1:0]  rm;

        // Reset state.
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.in0   = '0;
        bus.in1   = '0;
        bus.mode  = '0;
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", {31'b0, bus.result}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal operands: all chunks, busy for 5 cycles.
        run_op("eq_a0a0", 16'hA0A0, 16'hA0A0, 2'b00);
        // Early termination on the top chunk.
        run_op("ltu_early", 16'h1234, 16'h4321, 2'b01);
        run_op("ne_early", 16'h1234, 16'h4321, 2'b11);
        run_op("eq_early", 16'h1234, 16'h4321, 2'b00);
        // Signed versus unsigned ordering.
        run_op("lt_signed", 16'h8000, 16'h0001, 2'b10);
        run_op("ltu_unsigned", 16'h8000, 16'h0001, 2'b01);
        run_op("lt_equal_ffff", 16'hFFFF, 16'hFFFF, 2'b10);

        // Start during busy is ignored.
        bus.start = 1'b1;
        bus.in0   = 16'h0000;
        bus.in1   = 16'h0000;
        bus.mode  = 2'b00;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("ign_done_c%0d", n), {31'b0, bus.done}, {31'b0, (n == 5)});
            if (n == 5) check("ign_result", {31'b0, bus.result}, 32'd1);
            if (n == 1) bus.start = 1'b0;
            if (n == 2) begin
                bus.start = 1'b1;
                bus.in0   = 16'hFFFF;
                bus.in1   = 16'h0000;
            end
            if (n == 3) bus.start = 1'b0;
        end

        // Reset mid-operation aborts without a done pulse.
        bus.start = 1'b1;
        bus.in0   = 16'h5555;
        bus.in1   = 16'h5555;
        bus.mode  = 2'b00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_busy_pre", {31'b0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'b0, bus.done}, 32'd0);
        check("mid_rst_result", {31'b0, bus.result}, 32'd0);
        check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
        // Start held during reset must not be taken.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        check("rst_start_busy1", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        check("rst_start_busy2", {31'b0, bus.busy}, 32'd0);
        check("rst_start_done", {31'b0, bus.done}, 32'd0);
        rst_n = 1'b1;
        run_op("post_rst_ltu", 16'h0001, 16'h0002, 2'b01);

        // Random back-to-back runs; half share leading chunks to vary latency.
        for (int r = 0; r < 50; r++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            rm = 2'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d", r), ra, rb, rm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4: bits compared per cycle; N = WIDTH/CHUNK chunks.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a comparison; honoured only in IDLE.
REQ-006 in0  input  WIDTH  first operand, sampled on the accepting edge only.
REQ-007 in1  input  WIDTH  second operand, sampled on the accepting edge only.
REQ-008 mode  input  2  comparison mode, sampled with the operands: 00 eq, 01 ltu (in0 < in1 unsigned), 10 lt (signed two's complement), 11 ne.
REQ-009 busy  output  1  high while a comparison is in progress (states CMP and DONE).
REQ-010 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-011 result  output  1  comparison outcome; held stable from the done cycle until the next accepted start.

Function
REQ-012 The FSM SHALL have states IDLE, CMP and DONE; only the states listed under these requirements are reachable.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL latch in0, in1 and mode, set chunk index to N-1 (the most significant chunk), and enter CMP.
REQ-014 For mode 10, the block SHALL invert bit WIDTH-1 of both latched operands, so that the unsigned chunk compare gives the signed ordering.
REQ-015 Each CMP cycle SHALL compare exactly one CHUNK-bit slice, at the current index, MSB chunk first.
REQ-016 If the slices differ, the outcome SHALL be decided in that cycle: eq=0; ne=1; ltu/lt=1 if the in0 slice < the in1 slice, else 0. The FSM SHALL then enter DONE (early termination).
REQ-017 If the slices are equal and index=0, the outcome SHALL be eq=1, ne=0, ltu=0, lt=0, and the FSM SHALL enter DONE.
REQ-018 If the slices are equal and index>0, the index SHALL decrement and the FSM SHALL remain in CMP.
REQ-019 In DONE, done=1 and result SHALL show the outcome; the next state is always IDLE.
REQ-020 Latency: if start is accepted at edge k and j chunks are examined (1<=j<=N), done SHALL be high in the cycle after edge k+j; maximum N+1 cycles from start, minimum 2.
REQ-021 start asserted while busy=1 (CMP or DONE) SHALL be ignored, with no effect on latched operands, mode, index or result.
REQ-022 Back-to-back operation: start=1 in the cycle after DONE (IDLE) SHALL be accepted; there is no other dead cycle.
REQ-023 Changes on in0, in1 or mode after acceptance SHALL NOT affect the running comparison.
REQ-024 busy SHALL be 0 in IDLE and 1 in CMP and DONE.
REQ-025 done SHALL be 1 only in DONE.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, result=0, index=0 and latched operands/mode=0.
REQ-027 Reset asserted during CMP or DONE SHALL abort the comparison; no done pulse SHALL appear for the aborted operation.
REQ-028 start SHALL be ignored while rst_n=0; the first start is accepted on the first rising edge with rst_n=1.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-029 Equal operands: start, in0=in1=16'hA0A0, mode=00 -> all 4 chunks examined; done in the cycle after edge k+4; result=1; busy high for 5 cycles.
REQ-030 Early termination: in0=16'h1234, in1=16'h4321, mode=01 -> top chunk decides; done in the cycle after edge k+1; result=1. Same operands with mode=11 -> result=1; with mode=00 -> result=0.
REQ-031 Signed vs unsigned: in0=16'h8000, in1=16'h0001 -> mode=10 gives result=1; mode=01 gives result=0. in0=in1=16'hFFFF with mode=10 -> result=0 after 4 chunks.
REQ-032 Ignored start: start at edge k with 16'h0000/16'h0000 mode=00, then start at edge k+2 with 16'hFFFF/16'h0000 -> single done pulse in the cycle after edge k+4 with result=1, and no second operation.
REQ-033 Reset mid-operation: rst_n=0 between edges k+2 and k+3 -> busy=0, done=0, result=0 immediately; no done pulse follows. After release, start with 16'h0001/16'h0002 mode=01 -> result=1 after 4 chunks.
REQ-034 Random: 50 runs with random in0/in1/mode checked against a reference model, including back-to-back starts issued in the cycle after each done.
